// File: rtl/digital_tube_scan.sv
`default_nettype none
// ============================================================================
//  Module   : digital_tube_scan
//  Purpose  : Time-multiplexed 8-digit seven-segment driver. CPU writes land
//             in a shadow register and are swapped onto the display only at a
//             frame boundary, so a frame never shows a mix of old and new
//             digits. One hex digit is scanned per refresh slot.
//  Ports    : clk       - cpu clock
//             rst       - asynchronous reset, active-low
//             wr_en     - one-cycle write strobe
//             wr_data   - 32-bit value, nibble i drives digit i (0 = right)
//             blank_lz  - 1: suppress leading zeros
//             disp_en   - 0: all anodes inactive, scanning continues
//             seg_out   - {dp,g,f,e,d,c,b,a}
//             an_out    - digit select, one-hot when lit
//             upd_ack   - 1-cycle pulse when a pending value becomes visible
//  Revision : 1.0 - initial release
// ============================================================================
module digital_tube_scan #(
   parameter int REFRESH_DIV  = 100_000,
   parameter bit SEG_ACT_HIGH = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_data,
   input  logic        blank_lz,
   input  logic        disp_en,
   output logic [7:0]  seg_out,
   output logic [7:0]  an_out,
   output logic        upd_ack
);

   localparam int       C_DIV_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam bit [7:0] C_OUT_OFF = SEG_ACT_HIGH ? 8'h00 : 8'hFF;
   localparam bit [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(REFRESH_DIV - 1);

   logic [C_DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [2:0]         idx_q, idx_d;
   logic [31:0]        pend_q, pend_d;
   logic               pend_valid_q, pend_valid_d;
   logic [31:0]        disp_reg_q, disp_reg_d;
   logic               upd_ack_q, upd_ack_d;
   logic [7:0]         an_q, an_d;
   logic [7:0]         seg_q, seg_d;

   logic               tick;
   logic               frame_end;
   logic               swap;
   logic [31:0]        shifted;
   logic               blank;
   logic [7:0]         an_raw;
   logic [7:0]         seg_raw;

   // Hex font, gfedcba
   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0: f = 7'h3F;
         4'h1: f = 7'h06;
         4'h2: f = 7'h5B;
         4'h3: f = 7'h4F;
         4'h4: f = 7'h66;
         4'h5: f = 7'h6D;
         4'h6: f = 7'h7D;
         4'h7: f = 7'h07;
         4'h8: f = 7'h7F;
         4'h9: f = 7'h6F;
         4'hA: f = 7'h77;
         4'hB: f = 7'h7C;
         4'hC: f = 7'h39;
         4'hD: f = 7'h5E;
         4'hE: f = 7'h79;
         default: f = 7'h71;
      endcase
      return f;
   endfunction

   always_comb begin
      tick      = (div_cnt_q == C_DIV_LAST);
      frame_end = tick && (idx_q == 3'd7);
      swap      = frame_end && pend_valid_q;

      div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
      idx_d     = tick ? idx_q + 3'd1 : idx_q;

      // Swap consumes the old shadow value; a same-cycle write refills the
      // shadow and keeps it pending for the following frame.
      disp_reg_d   = swap ? pend_q : disp_reg_q;
      pend_d       = wr_en ? wr_data : pend_q;
      pend_valid_d = wr_en ? 1'b1 : (swap ? 1'b0 : pend_valid_q);
      upd_ack_d    = swap;

      // Digit idx is a leading zero when it and every digit above it are 0.
      shifted = disp_reg_q >> {idx_q, 2'b00};
      blank   = blank_lz && (idx_q != 3'd0) && (shifted == 32'd0);

      an_raw  = (!disp_en || blank) ? 8'h00 : (8'h01 << idx_q);
      seg_raw = blank ? 8'h00 : {1'b0, hex_font(shifted[3:0])};

      an_d  = SEG_ACT_HIGH ? an_raw  : ~an_raw;
      seg_d = SEG_ACT_HIGH ? seg_raw : ~seg_raw;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q    <= '0;
         idx_q        <= 3'd0;
         pend_q       <= 32'd0;
         pend_valid_q <= 1'b0;
         disp_reg_q   <= 32'd0;
         upd_ack_q    <= 1'b0;
         an_q         <= C_OUT_OFF;
         seg_q        <= C_OUT_OFF;
      end else begin
         div_cnt_q    <= div_cnt_d;
         idx_q        <= idx_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         disp_reg_q   <= disp_reg_d;
         upd_ack_q    <= upd_ack_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
      end
   end

   assign seg_out = seg_q;
   assign an_out  = an_q;
   assign upd_ack = upd_ack_q;

endmodule
`default_nettype wire
